// File: rtl/morse_sequencer.sv
// morse_sequencer: serialises one International Morse letter (A-Z) on DotDashOut, one pattern bit per CLK_DIV-clock unit,
// with Start/Busy/Done handshake, optional repeat with GAP_UNITS of silence between copies, and Abort.
module morse_sequencer #(
    parameter int CLK_DIV   = 250,
    parameter int PAT_W     = 16,
    parameter int GAP_UNITS = 3
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic [4:0] Letter,
    input  logic       Repeat,
    input  logic       Abort,
    output logic       DotDashOut,
    output logic       Busy,
    output logic       Done
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2((GAP_UNITS > 13 ? GAP_UNITS : 13) + 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [4:0]       let_q, let_d;
    logic             rep_q, rep_d, done_q, done_d;
    logic [17:0]      ent;
    logic             tick, last;

    // {length, pattern right-justified in 13 bits}
    function automatic logic [17:0] morse(input logic [4:0] l);
        case (l)
            5'd0:  return {5'd5,  13'b10111};
            5'd1:  return {5'd9,  13'b111010101};
            5'd2:  return {5'd11, 13'b11101011101};
            5'd3:  return {5'd7,  13'b1110101};
            5'd4:  return {5'd1,  13'b1};
            5'd5:  return {5'd9,  13'b101011101};
            5'd6:  return {5'd9,  13'b111011101};
            5'd7:  return {5'd7,  13'b1010101};
            5'd8:  return {5'd3,  13'b101};
            5'd9:  return {5'd13, 13'b1011101110111};
            5'd10: return {5'd9,  13'b111010111};
            5'd11: return {5'd9,  13'b101110101};
            5'd12: return {5'd7,  13'b1110111};
            5'd13: return {5'd5,  13'b11101};
            5'd14: return {5'd11, 13'b11101110111};
            5'd15: return {5'd11, 13'b10111011101};
            5'd16: return {5'd13, 13'b1110111010111};
            5'd17: return {5'd7,  13'b1011101};
            5'd18: return {5'd5,  13'b10101};
            5'd19: return {5'd3,  13'b111};
            5'd20: return {5'd7,  13'b1010111};
            5'd21: return {5'd9,  13'b101010111};
            5'd22: return {5'd9,  13'b101110111};
            5'd23: return {5'd11, 13'b11101010111};
            5'd24: return {5'd13, 13'b1110101110111};
            5'd25: return {5'd11, 13'b11101110101};
            default: return '0;
        endcase
    endfunction

    function automatic logic [PAT_W-1:0] justify(input logic [17:0] e);
        return PAT_W'(e[12:0]) << (PAT_W - int'(e[17:13]));
    endfunction

    always_comb begin
        ent     = morse(state_q == IDLE ? Letter : let_q);
        tick    = div_q == DIV_W'(CLK_DIV - 1);
        last    = tick && cnt_q == CNT_W'(1);
        state_d = state_q;
        div_d   = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
        cnt_d   = tick ? cnt_q - 1'b1 : cnt_q;
        pat_d   = tick ? pat_q << 1 : pat_q;
        let_d   = let_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
        if (Abort) begin
            state_d = IDLE;
            div_d   = '0;
            pat_d   = '0;
        end else if (state_q == IDLE) begin
            if (Start && Letter < 5'd26) begin
                state_d = SEND;
                cnt_d   = CNT_W'(ent[17:13]);
                pat_d   = justify(ent);
                let_d   = Letter;
                rep_d   = Repeat;
            end
        end else if (last && state_q == SEND && rep_q) begin
            state_d = GAP;
            cnt_d   = CNT_W'(GAP_UNITS);
            pat_d   = '0;
        end else if (last && state_q == GAP && Repeat) begin
            state_d = SEND;
            cnt_d   = CNT_W'(ent[17:13]);
            pat_d   = justify(ent);
        end else if (last) begin
            state_d = IDLE;
            pat_d   = '0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            let_q   <= '0;
            rep_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            let_q   <= let_d;
            rep_q   <= rep_d;
            done_q  <= done_d;
        end
    end

    assign DotDashOut = pat_q[PAT_W-1];
    assign Busy       = state_q != IDLE;
    assign Done       = done_q;
endmodule

// File: tb/tb_morse_sequencer.sv
// tb_morse_sequencer: table of letters with Morse strings plus hand-written
// repeat/abort/reset sequences; expected per-cycle outputs are queued and popped.
module tb_morse_sequencer;
    localparam int CD = 4;
    localparam int GU = 3;

    logic       ClockIn = 1'b0;
    logic       Reset   = 1'b1;
    logic       Start   = 1'b0;
    logic [4:0] Letter  = '0;
    logic       Repeat  = 1'b0;
    logic       Abort   = 1'b0;
    logic       DotDashOut, Busy, Done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic  dot;
        logic  busy;
        logic  done;
        string name;
    } exp_t;

    typedef struct {
        logic [4:0] letter;
        string      code;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[26];

    morse_sequencer #(.CLK_DIV(CD), .PAT_W(16), .GAP_UNITS(GU)) dut (
        .ClockIn(ClockIn), .Reset(Reset), .Start(Start), .Letter(Letter),
        .Repeat(Repeat), .Abort(Abort), .DotDashOut(DotDashOut), .Busy(Busy), .Done(Done)
    );

    always #5 ClockIn = ~ClockIn;

    function automatic void push(input logic d, input logic b, input logic dn, input string nm, input int n = 1);
        for (int i = 0; i < n; i++) exp_q.push_back('{d, b, dn, nm});
    endfunction

    // dot = 1 unit on, dash = 3 units on, 1 unit off between elements
    function automatic void push_code(input string code, input string nm);
        for (int i = 0; i < code.len(); i++) begin
            if (i > 0) push(1'b0, 1'b1, 1'b0, nm, CD);
            push(1'b1, 1'b1, 1'b0, nm, code[i] == "-" ? 3 * CD : CD);
        end
    endfunction

    task automatic cyc(input int n = 1);
        exp_t e;
        repeat (n) begin
            @(negedge ClockIn);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({DotDashOut, Busy, Done} !== {e.dot, e.busy, e.done}) begin
                    failures++;
                    $display("FAIL %s t=%0t dot/busy/done got=%b%b%b exp=%b%b%b", e.name, $time,
                             DotDashOut, Busy, Done, e.dot, e.busy, e.done);
                end
            end
            @(posedge ClockIn);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 5000) begin
            cyc(1);
            n++;
        end
    endtask

    initial begin
        vecs = '{'{5'd0, ".-"},   '{5'd1, "-..."},  '{5'd2, "-.-."},  '{5'd3, "-.."},
                 '{5'd4, "."},    '{5'd5, "..-."},  '{5'd6, "--."},   '{5'd7, "...."},
                 '{5'd8, ".."},   '{5'd9, ".---"},  '{5'd10, "-.-"},  '{5'd11, ".-.."},
                 '{5'd12, "--"},  '{5'd13, "-."},   '{5'd14, "---"},  '{5'd15, ".--."},
                 '{5'd16, "--.-"}, '{5'd17, ".-."}, '{5'd18, "..."},  '{5'd19, "-"},
                 '{5'd20, "..-"}, '{5'd21, "...-"}, '{5'd22, ".--"},  '{5'd23, "-..-"},
                 '{5'd24, "-.--"}, '{5'd25, "--.."}};

        @(posedge ClockIn);
        #1;
        push(1'b0, 1'b0, 1'b0, "reset", 3);
        cyc(2);
        Reset = 1'b0;
        cyc(1);

        push(1'b0, 1'b0, 1'b0, "pre_a", 10);
        cyc(10);
        push(1'b0, 1'b0, 1'b0, "a_start");
        push_code(".-", "a_bits");
        push(1'b0, 1'b0, 1'b1, "a_done");
        push(1'b0, 1'b0, 1'b0, "a_idle", 3);
        Start = 1'b1; Letter = 5'd0;
        cyc(1);
        Start = 1'b0;
        drain();

        foreach (vecs[i]) begin
            push(1'b0, 1'b0, 1'b0, $sformatf("v%0d_start", i));
            push_code(vecs[i].code, $sformatf("v%0d_bits", i));
            push(1'b0, 1'b0, 1'b1, $sformatf("v%0d_done", i));
            push(1'b0, 1'b0, 1'b0, $sformatf("v%0d_idle", i));
            Start = 1'b1; Letter = vecs[i].letter;
            cyc(1);
            Start = 1'b0; Letter = ~vecs[i].letter;
            drain();
        end

        push(1'b0, 1'b0, 1'b0, "rep_start");
        push(1'b1, 1'b1, 1'b0, "rep_e1", CD);
        push(1'b0, 1'b1, 1'b0, "rep_gap1", GU * CD);
        push(1'b1, 1'b1, 1'b0, "rep_e2", CD);
        push(1'b0, 1'b1, 1'b0, "rep_gap2", GU * CD);
        push(1'b0, 1'b0, 1'b1, "rep_done");
        push(1'b0, 1'b0, 1'b0, "rep_idle", 2);
        Start = 1'b1; Letter = 5'd4; Repeat = 1'b1;
        cyc(1);
        Start = 1'b0;
        cyc(17);
        Repeat = 1'b0;
        drain();

        push(1'b0, 1'b0, 1'b0, "busy_start");
        push_code(".-", "busy_a");
        push(1'b0, 1'b0, 1'b1, "busy_done");
        Start = 1'b1; Letter = 5'd0;
        cyc(1);
        Start = 1'b0;
        cyc(5);
        Start = 1'b1; Letter = 5'd19;
        cyc(1);
        Start = 1'b0;
        cyc(14);
        push_code(".", "b2b_e");
        push(1'b0, 1'b0, 1'b1, "b2b_done");
        push(1'b0, 1'b0, 1'b0, "b2b_idle", 2);
        Start = 1'b1; Letter = 5'd4;
        cyc(1);
        Start = 1'b0;
        drain();

        push(1'b0, 1'b0, 1'b0, "invalid", 12);
        Start = 1'b1; Letter = 5'd26;
        cyc(1);
        Letter = 5'd31;
        cyc(1);
        Start = 1'b0;
        drain();
        push(1'b0, 1'b0, 1'b0, "y_start");
        push_code("-.--", "y_bits");
        push(1'b0, 1'b0, 1'b1, "y_done");
        push(1'b0, 1'b0, 1'b0, "y_idle");
        Start = 1'b1; Letter = 5'd24;
        cyc(1);
        Start = 1'b0;
        drain();

        push(1'b0, 1'b0, 1'b0, "abort_start");
        push(1'b1, 1'b1, 1'b0, "abort_a", CD);
        push(1'b0, 1'b1, 1'b0, "abort_a", CD);
        push(1'b1, 1'b1, 1'b0, "abort_a");
        push(1'b0, 1'b0, 1'b0, "abort_idle", 30);
        Start = 1'b1; Letter = 5'd0;
        cyc(1);
        Start = 1'b0;
        cyc(8);
        Abort = 1'b1;
        cyc(1);
        Abort = 1'b0;
        drain();

        push(1'b0, 1'b0, 1'b0, "rst_start");
        push(1'b1, 1'b1, 1'b0, "rst_a", CD);
        push(1'b0, 1'b1, 1'b0, "rst_a");
        push(1'b0, 1'b0, 1'b0, "rst_idle", 30);
        Start = 1'b1; Letter = 5'd0;
        cyc(1);
        Start = 1'b0;
        cyc(4);
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        drain();

        push(1'b0, 1'b0, 1'b0, "abort_start_idle", 6);
        Start = 1'b1; Abort = 1'b1; Letter = 5'd0;
        cyc(1);
        Start = 1'b0; Abort = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
